vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

VGA 640×480 timing generator for the text-mode display path. It derives a pixel-rate enable from the system clock, since there is no PLL and only a single clock domain. It runs horizontal/vertical counters and decodes syncs, the active-video window, and a once-per-frame blanking-start pulse. Downstream tile RAM, font ROM and pixel mux consume `x`, `y`, `active` and delay them to match their own pipeline latency.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (≥1); 50 MHz → 25 MHz pixel rate.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing in lines.
- `SYNC_POL`, 0: sync pulse level (0 = active-low).
- `clk` in 1: system clock. One clock; all logic on its rising edge.
- `rst_n` in 1: reset. Synchronous and active-low.
- `pix_en` out 1: high for one `clk` in every `CLK_DIV`. Counters advance on it.
- `x` out 10: horizontal count, 0..H_TOTAL-1 (H_TOTAL = sum of the H params = 800).
- `y` out 10: vertical count, 0..V_TOTAL-1 (V_TOTAL = 525).
- `h_sync` out 1: horizontal sync.
- `v_sync` out 1: vertical sync.
- `active` out 1: visible-pixel window.
- `blanking_start` out 1: one-`clk` pulse at the start of vertical blanking.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (`div_cnt` == CLK_DIV-1).
  - With CLK_DIV = 1, `pix_en` is constantly 1.
- On `pix_en`:
  - If `x` == H_TOTAL-1: `x` ← 0, and `y` advances. If `y` == V_TOTAL-1 then `y` ← 0, else `y` ← `y`+1.
  - Else `x` ← `x`+1.
- `x`, `y` and `div_cnt` are registers. All other outputs are combinational decodes of the current registers, so they are consistent with `x`/`y` in the same cycle.
- `active` = (`x` < H_ACTIVE) && (`y` < V_ACTIVE).
- Horizontal sync region: H_ACTIVE+H_FP ≤ `x` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - `h_sync` = SYNC_POL inside the region, ~SYNC_POL outside.
- Vertical sync region: V_ACTIVE+V_FP ≤ `y` < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - `v_sync` = SYNC_POL inside the region, ~SYNC_POL outside.
  - `v_sync` depends only on `y`, so it changes exactly when `y` changes, at the `x` wrap.
- `blanking_start` = `pix_en` && `x`==0 && `y`==V_ACTIVE.
  - Fires exactly once per frame and is exactly one `clk` wide, regardless of CLK_DIV.
- `x`/`y` are unsigned 10-bit values. Parameter totals must be ≤ 1024; out-of-range totals are unsupported.
- Downstream text mapping (informative): column = `x`[9:3] (80 columns), row = `y`[9:4] (30 rows).

## Timing
- Reset (`rst_n` low at a `clk` edge) forces `div_cnt`=0, `x`=0, `y`=0.
  - In the cycle after reset: `active`=1, `h_sync`=`v_sync`=~SYNC_POL, `blanking_start`=0, and `pix_en`=1 only if CLK_DIV=1.
- Reset asserted mid-frame restarts the frame at (0,0) on the next edge. No partial pulse is emitted afterwards.
- Reset has priority over counting.
- First `pix_en` after reset release occurs CLK_DIV-1 cycles later, i.e. the `clk` edge at which `div_cnt` = CLK_DIV-1.
- One pixel lasts CLK_DIV clocks. One line is 800 × CLK_DIV clocks. One frame is 420000 × CLK_DIV clocks.
- Output latency from counter register to decode is 0 cycles. Any pipeline alignment is the consumer's responsibility.
- Wrap of `x` and `y` happens on the same `pix_en` edge; frame wrap is (799,524) → (0,0).

## Test plan
- Reset, CLK_DIV=2, release → `x`=0, `y`=0, `active`=1, `h_sync`=`v_sync`=1. `pix_en` toggles 0,1,0,1 and `x` increments every 2 clks.
- Run one line → `active` falls when `x` goes 639→640. `h_sync` low for `x`=656..751 (96 pixels = 192 clks). `x` wraps 799→0 with `y` 0→1.
- Run to frame end → `v_sync` low for `y`=490..491 only. `y` wraps 524→0 at `x` wrap. Frame period is 840000 clks.
- Count `blanking_start` over 3 frames → exactly 3 one-clk pulses, each at `x`=0, `y`=480, spaced 840000 clks apart.
- Assert `rst_n`=0 for one cycle at `y`=300 → next cycle `x`=`y`=0. No `blanking_start` until `y` next reaches 480.
- CLK_DIV=1 → `pix_en` stuck at 1. Line is 800 clks and frame is 420000 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate enable from the system clock, h/v counters,
// and combinational sync / active-window / blanking-start decodes of those counters.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       h_sync,
    output logic       v_sync,
    output logic       active,
    output logic       blanking_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned EW       = CW + 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0]    x_q, x_d;
    logic [CW-1:0]    y_q, y_d;
    logic [EW-1:0]    x_ext, y_ext;
    logic             x_last, y_last;
    logic             in_hsync, in_vsync;

    // Pixel enable fires on the last divider count; with CLK_DIV=1 it is always high.
    assign pix_en = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign x_last = (x_q == CW'(H_TOTAL - 1));
    assign y_last = (y_q == CW'(V_TOTAL - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        x_d       = x_q;
        y_d       = y_q;
        if (pix_en) begin
            div_cnt_d = '0;
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    // Decodes compare in one extra bit so region ends at 1024 remain representable.
    assign x_ext    = {1'b0, x_q};
    assign y_ext    = {1'b0, y_q};
    assign in_hsync = (x_ext >= EW'(HS_START)) && (x_ext < EW'(HS_END));
    assign in_vsync = (y_ext >= EW'(VS_START)) && (y_ext < EW'(VS_END));

    assign x              = x_q;
    assign y              = y_q;
    assign active         = (x_ext < EW'(H_ACTIVE)) && (y_ext < EW'(V_ACTIVE));
    assign h_sync         = in_hsync ? SYNC_POL : ~SYNC_POL;
    assign v_sync         = in_vsync ? SYNC_POL : ~SYNC_POL;
    assign blanking_start = pix_en && (x_q == '0) && (y_q == CW'(V_ACTIVE));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-width horizontal timing with a shortened
// vertical frame (8 lines) so multi-frame behaviour fits in a short run.
module tb_vga_timing_gen;

    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned LINE2  = 1600;
    localparam int unsigned FRAME2 = 8 * LINE2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pe0, hs0, vs0, ac0, bs0;
    logic [9:0] x0, y0;
    logic       pe1, hs1, vs1, ac1, bs1;
    logic [9:0] x1, y1;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(2), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe0), .x(x0), .y(y0),
        .h_sync(hs0), .v_sync(vs0), .active(ac0), .blanking_start(bs0)
    );

    vga_timing_gen #(.CLK_DIV(1), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe1), .x(x1), .y(y1),
        .h_sync(hs1), .v_sync(vs1), .active(ac1), .blanking_start(bs1)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned cnt, hs_clks, vs_clks, bs_cnt, bs_bad, pe_zero;
        int unsigned bs_t [3];
        logic [9:0]  px, py, hs_first, hs_last, vs_first, vs_last;

        bs_t = '{0, 0, 0};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_x", 32'(x0), 0);
        check("rst_y", 32'(y0), 0);
        check("rst_active", 32'(ac0), 1);
        check("rst_hsync", 32'(hs0), 1);
        check("rst_vsync", 32'(vs0), 1);
        check("rst_bstart", 32'(bs0), 0);
        check("rst_pix_en_div2", 32'(pe0), 0);
        check("rst_pix_en_div1", 32'(pe1), 1);

        // Release: pix_en toggles, x advances every second clock
        rst_n = 1'b1;
        tick();
        check("rel1_pe", 32'(pe0), 1);
        check("rel1_x", 32'(x0), 0);
        check("rel1_x_div1", 32'(x1), 1);
        tick();
        check("rel2_pe", 32'(pe0), 0);
        check("rel2_x", 32'(x0), 1);
        tick();
        check("rel3_pe", 32'(pe0), 1);
        check("rel3_x", 32'(x0), 1);
        tick();
        check("rel4_pe", 32'(pe0), 0);
        check("rel4_x", 32'(x0), 2);

        // Active window falls at 639 -> 640
        px  = x0;
        cnt = 0;
        while (ac0 && cnt < 4000) begin
            px = x0;
            tick();
            cnt++;
        end
        check("act_fall_seen", 32'(ac0), 0);
        check("act_fall_prev_x", 32'(px), 639);
        check("act_fall_x", 32'(x0), 640);

        // Rest of line: h_sync pulse extent and line wrap
        hs_clks  = 0;
        hs_first = 10'd1023;
        hs_last  = 10'd0;
        cnt      = 0;
        while (x0 != 0 && cnt < 4000) begin
            if (!hs0) begin
                hs_clks++;
                if (x0 < hs_first) hs_first = x0;
                if (x0 > hs_last) hs_last = x0;
            end
            px = x0;
            tick();
            cnt++;
        end
        check("line_wrap_x", 32'(x0), 0);
        check("line_wrap_prev_x", 32'(px), 799);
        check("line_wrap_y", 32'(y0), 1);
        check("hsync_clks", hs_clks, 192);
        check("hsync_first_x", 32'(hs_first), 656);
        check("hsync_last_x", 32'(hs_last), 751);
        check("line1_active", 32'(ac0), 1);

        // Run to frame end: v_sync extent, frame wrap, one blanking pulse
        vs_clks  = 0;
        vs_first = 10'd1023;
        vs_last  = 10'd0;
        bs_cnt   = 0;
        py       = y0;
        cnt      = 0;
        while (y0 != 0 && cnt < 20000) begin
            if (!vs0) begin
                vs_clks++;
                if (y0 < vs_first) vs_first = y0;
                if (y0 > vs_last) vs_last = y0;
            end
            if (bs0) bs_cnt++;
            py = y0;
            px = x0;
            tick();
            cnt++;
        end
        check("frame_wrap_y", 32'(y0), 0);
        check("frame_wrap_x", 32'(x0), 0);
        check("frame_wrap_prev_y", 32'(py), 7);
        check("frame_wrap_prev_x", 32'(px), 799);
        check("vsync_clks", vs_clks, 2 * LINE2);
        check("vsync_first_y", 32'(vs_first), 5);
        check("vsync_last_y", 32'(vs_last), 6);
        check("bstart_first_frame", bs_cnt, 1);

        // Three full frames from frame start: pulse count, position, spacing
        bs_cnt = 0;
        bs_bad = 0;
        for (int t = 0; t < int'(3 * FRAME2); t++) begin
            if (bs0) begin
                if (bs_cnt < 3) bs_t[bs_cnt] = 32'(t);
                bs_cnt++;
                if (x0 != 0 || y0 != 10'(VA)) bs_bad++;
            end
            tick();
        end
        check("bstart_3frames", bs_cnt, 3);
        check("bstart_misplaced", bs_bad, 0);
        check("bstart_t0", bs_t[0], 4 * LINE2 + 1);
        check("bstart_gap01", bs_t[1] - bs_t[0], FRAME2);
        check("bstart_gap12", bs_t[2] - bs_t[1], FRAME2);

        // Mid-frame reset at line 2, mid-line
        cnt = 0;
        while (!(y0 == 2 && x0 >= 300) && cnt < 20000) begin
            tick();
            cnt++;
        end
        check("midrst_reached_y", 32'(y0), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_x", 32'(x0), 0);
        check("midrst_y", 32'(y0), 0);
        check("midrst_pe", 32'(pe0), 0);
        check("midrst_hsync", 32'(hs0), 1);
        check("midrst_vsync", 32'(vs0), 1);
        check("midrst_bstart", 32'(bs0), 0);
        cnt = 0;
        while (!bs0 && cnt < 7000) begin
            tick();
            cnt++;
        end
        check("midrst_first_bstart_clk", cnt, 4 * LINE2 + 1);
        check("midrst_first_bstart_y", 32'(y0), VA);

        // CLK_DIV=1: 800-clock line, 6400-clock frame, pix_en never low
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("div1_rst_pe", 32'(pe1), 1);
        check("div1_rst_x", 32'(x1), 0);
        pe_zero = 0;
        bs_cnt  = 0;
        cnt     = 0;
        while (!(x1 == 0 && y1 == 1) && cnt < 2000) begin
            if (!pe1) pe_zero++;
            if (bs1) bs_cnt++;
            tick();
            cnt++;
        end
        check("div1_line_clks", cnt, 800);
        while (y1 != 0 && cnt < 10000) begin
            if (!pe1) pe_zero++;
            if (bs1) bs_cnt++;
            tick();
            cnt++;
        end
        check("div1_frame_clks", cnt, 6400);
        check("div1_pe_low_clks", pe_zero, 0);
        check("div1_bstart_count", bs_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
